// File: rtl/wbnn_fifo_pkg.sv
// Shared register map and bit positions for the Wishbone <-> NN FIFO bridge.
// The optional interrupt path (WBNN_FIFO_IRQ_EN) uses the STATUS/CTRL indices below.
package wbnn_fifo_pkg;

    // Word offsets within the 16-byte window (byte address bits [3:2])
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_IN_FULL   = 0;
    localparam int ST_IN_EMPTY  = 1;
    localparam int ST_OUT_FULL  = 2;
    localparam int ST_OUT_EMPTY = 3;
    localparam int ST_OVF       = 4;
    localparam int ST_UDF       = 5;
    localparam int ST_IRQ       = 6;
    localparam int ST_IRQ_EN    = 7;
    localparam int ST_IN_CNT    = 8;
    localparam int ST_OUT_CNT   = 16;

    localparam int CTRL_FLUSH_IN  = 0;
    localparam int CTRL_FLUSH_OUT = 1;
    localparam int CTRL_CLR_FLAGS = 2;
    localparam int CTRL_IRQ_EN    = 3;

endpackage

// File: rtl/wbnn_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush; refuses push when full
// and pop when empty, regardless of the other side acting in the same cycle.
module wbnn_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [DATA_W-1:0]          head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers/count define validity, so the
    // array stays a plain RAM instead of DEPTH*DATA_W resettable flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: non-blocking assignments keep every flop updating from the
    // pre-edge values, so pointer and count updates never race each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wishbone_nn_fifo_bridge.sv
// Wishbone classic slave with inbound/outbound FIFOs to the NN core, STATUS/CTRL
// registers and sticky ovf/udf; threshold interrupt only when WBNN_FIFO_IRQ_EN is defined.
module wishbone_nn_fifo_bridge
    import wbnn_fifo_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 8,
    parameter int          THRESH    = DEPTH / 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              core_in_valid_o,
    output logic [DATA_W-1:0] core_in_data_o,
    input  logic              core_in_ready_i,
    input  logic              core_out_valid_i,
    input  logic [DATA_W-1:0] core_out_data_i,
    output logic              core_out_ready_o,
    output logic              irq_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              hit;
    logic              accept;
    logic [1:0]        reg_sel;
    logic              data_wr;
    logic              data_rd;
    logic              ctrl_wr;
    logic              flush_in;
    logic              flush_out;
    logic              clr_flags;

    logic              in_full;
    logic              in_empty;
    logic [CW-1:0]     in_count;
    logic              out_full;
    logic              out_empty;
    logic [CW-1:0]     out_count;
    logic [DATA_W-1:0] out_head;

    logic              ovf;
    logic              udf;
    logic              ovf_evt;
    logic              udf_evt;
    logic              thresh_hit;
    logic [31:0]       status;
    logic [31:0]       rd_value;
    logic              unused_bits;

    // An access is taken only while ack is low, giving one access per two cycles.
    assign hit     = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign accept  = hit && !wbs_ack_o;
    assign reg_sel = wbs_adr_i[3:2];

    assign data_wr   = accept && wbs_we_i && (reg_sel == REG_DATA);
    assign data_rd   = accept && !wbs_we_i && (reg_sel == REG_DATA);
    assign ctrl_wr   = accept && wbs_we_i && (reg_sel == REG_CTRL);
    assign flush_in  = ctrl_wr && wbs_dat_i[CTRL_FLUSH_IN];
    assign flush_out = ctrl_wr && wbs_dat_i[CTRL_FLUSH_OUT];
    assign clr_flags = ctrl_wr && wbs_dat_i[CTRL_CLR_FLAGS];

    wbnn_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_in_fifo (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .push      (data_wr),
        .push_data (wbs_dat_i[DATA_W-1:0]),
        .pop       (core_in_ready_i),
        .flush     (flush_in),
        .head      (core_in_data_o),
        .full      (in_full),
        .empty     (in_empty),
        .count     (in_count)
    );

    wbnn_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_out_fifo (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .push      (core_out_valid_i),
        .push_data (core_out_data_i),
        .pop       (data_rd),
        .flush     (flush_out),
        .head      (out_head),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count)
    );

    assign core_in_valid_o  = !in_empty;
    assign core_out_ready_o = !out_full;

    // A flushed push is not an overflow; a new event outranks a same-cycle clear.
    assign ovf_evt    = data_wr && in_full && !flush_in;
    assign udf_evt    = data_rd && out_empty;
    assign thresh_hit = (out_count >= CW'(THRESH));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf_evt || (ovf && !clr_flags);
            udf <= udf_evt || (udf && !clr_flags);
        end
    end

`ifdef WBNN_FIFO_IRQ_EN
    logic irq_en;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            end
            irq_o <= irq_en && (thresh_hit || ovf || udf);
        end
    end

    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};
`else
    assign irq_o       = 1'b0;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i, thresh_hit};
`endif

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        status                    = '0;
        status[ST_IN_FULL]        = in_full;
        status[ST_IN_EMPTY]       = in_empty;
        status[ST_OUT_FULL]       = out_full;
        status[ST_OUT_EMPTY]      = out_empty;
        status[ST_OVF]            = ovf;
        status[ST_UDF]            = udf;
`ifdef WBNN_FIFO_IRQ_EN
        status[ST_IRQ]            = irq_o;
        status[ST_IRQ_EN]         = irq_en;
`endif
        status[ST_IN_CNT +: 8]    = 8'(in_count);
        status[ST_OUT_CNT +: 8]   = 8'(out_count);
    end

    always_comb begin
        rd_value = '0;
        if (!wbs_we_i) begin
            case (reg_sel)
                REG_DATA:   rd_value = out_empty ? 32'h0 : 32'(out_head);
                REG_STATUS: rd_value = status;
                default:    rd_value = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= accept ? rd_value : 32'h0;
        end
    end

endmodule

// File: tb/tb_wishbone_nn_fifo_bridge.sv
// Scoreboard bench for wishbone_nn_fifo_bridge: stimulus queues expected bus and
// core-side responses, monitors pop and compare. Define WBNN_FIFO_IRQ_EN for the irq build.
module tb_wishbone_nn_fifo_bridge;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] A_DAT = BASE + 32'h0;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_CTL = BASE + 32'h8;
    localparam logic [31:0] A_RSV = BASE + 32'hC;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        core_in_valid_o;
    logic [31:0] core_in_data_o;
    logic        core_in_ready_i;
    logic        core_out_valid_i;
    logic [31:0] core_out_data_i;
    logic        core_out_ready_o;
    logic        irq_o;

    int   errors = 0;
    int   checks = 0;
    exp_t bus_q[$];
    logic [31:0] in_q[$];
    exp_t mon_e;

    wishbone_nn_fifo_bridge #(
        .BASE_ADDR (BASE),
        .DATA_W    (32),
        .DEPTH     (8),
        .THRESH    (4)
    ) dut (
        .wb_clk_i         (wb_clk_i),
        .wb_rst_ni        (wb_rst_ni),
        .wbs_stb_i        (wbs_stb_i),
        .wbs_cyc_i        (wbs_cyc_i),
        .wbs_we_i         (wbs_we_i),
        .wbs_sel_i        (wbs_sel_i),
        .wbs_adr_i        (wbs_adr_i),
        .wbs_dat_i        (wbs_dat_i),
        .wbs_ack_o        (wbs_ack_o),
        .wbs_dat_o        (wbs_dat_o),
        .core_in_valid_o  (core_in_valid_o),
        .core_in_data_o   (core_in_data_o),
        .core_in_ready_i  (core_in_ready_i),
        .core_out_valid_i (core_out_valid_i),
        .core_out_data_i  (core_out_data_i),
        .core_out_ready_o (core_out_ready_o),
        .irq_o            (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor: every ack consumes one queued expectation; idle data must be 0.
    always @(negedge wb_clk_i) begin
        if (wbs_ack_o) begin
            if (bus_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = bus_q.pop_front();
                check(mon_e.tag, wbs_dat_o, mon_e.val);
            end
        end else begin
            check("dat_idle_zero", wbs_dat_o, 32'h0);
        end
    end

    // Core-side monitor: each inbound handshake must present the next queued word.
    always @(negedge wb_clk_i) begin
        if (wb_rst_ni && core_in_valid_o && core_in_ready_i) begin
            if (in_q.size() == 0) begin
                check("core_in_unexpected", 32'd1, 32'd0);
            end else begin
                check("core_in_data", core_in_data_o, in_q.pop_front());
            end
        end
    end

    // Called one ns after a rising edge; returns one ns after the edge that ends the ack cycle.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [31:0] exp, input string tag);
        int lat;
        bus_q.push_back('{tag, we ? 32'h0 : exp});
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = wdat;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        lat = 0;
        do begin
            @(negedge wb_clk_i);
            lat++;
        end while (!wbs_ack_o && lat < 8);
        check({tag, "_ack_latency"}, lat, 2);
        @(posedge wb_clk_i);
        #1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic core_push(input logic [31:0] d);
        core_out_valid_i = 1'b1;
        core_out_data_i  = d;
        @(posedge wb_clk_i);
        #1;
        core_out_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        wb_rst_ni        = 1'b0;
        wbs_stb_i        = 1'b0;
        wbs_cyc_i        = 1'b0;
        wbs_we_i         = 1'b0;
        wbs_sel_i        = 4'hF;
        wbs_adr_i        = '0;
        wbs_dat_i        = '0;
        core_in_ready_i  = 1'b0;
        core_out_valid_i = 1'b0;
        core_out_data_i  = '0;

        repeat (2) @(negedge wb_clk_i);
        check("rst_ack", wbs_ack_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_in_valid", core_in_valid_o, 0);
        check("rst_out_ready", core_out_ready_o, 1);
        wb_rst_ni = 1'b1;
        @(posedge wb_clk_i);
        #1;

        wb_xfer(0, A_ST, 0, 32'h0000_000A, "status_after_reset");

        // Inbound path: three words, popped in order by the core.
        for (int i = 1; i <= 3; i++) begin
            wb_xfer(1, A_DAT, i, 0, "wr_data");
            in_q.push_back(i);
        end
        check("in_valid_after_writes", core_in_valid_o, 1);
        check("in_head_first", core_in_data_o, 32'h1);
        core_in_ready_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        core_in_ready_i = 1'b0;
        check("in_valid_drained", core_in_valid_o, 0);
        wb_xfer(0, A_ST, 0, 32'h0000_000A, "status_in_drained");

        // Inbound overflow: ninth write dropped, flag sticky until cleared.
        for (int i = 0; i < 9; i++) begin
            wb_xfer(1, A_DAT, 32'h10 + i, 0, "wr_fill");
        end
        wb_xfer(0, A_ST, 0, 32'h0000_0819, "status_in_full_ovf");
        wb_xfer(1, A_CTL, 32'h4, 0, "ctrl_clear");
        wb_xfer(0, A_ST, 0, 32'h0000_0809, "status_ovf_cleared");
        wb_xfer(1, A_CTL, 32'h1, 0, "ctrl_flush_in");
        wb_xfer(0, A_ST, 0, 32'h0000_000A, "status_in_flushed");

        // Outbound path with underflow on the third read.
        core_push(32'hA5);
        core_push(32'h5A);
        wb_xfer(0, A_ST, 0, 32'h0002_0002, "status_out_two");
        wb_xfer(0, A_DAT, 0, 32'hA5, "rd_out_a5");
        wb_xfer(0, A_DAT, 0, 32'h5A, "rd_out_5a");
        wb_xfer(0, A_DAT, 0, 32'h0, "rd_out_empty");
        wb_xfer(0, A_ST, 0, 32'h0000_002A, "status_udf");
        wb_xfer(1, A_CTL, 32'h4, 0, "ctrl_clear_udf");
        wb_xfer(0, A_ST, 0, 32'h0000_000A, "status_udf_cleared");

        // Outbound full: push refused even with a same-cycle pop.
        for (int i = 0; i < 8; i++) begin
            core_push(32'h100 + i);
        end
        check("out_ready_full", core_out_ready_o, 0);
        wb_xfer(0, A_ST, 0, 32'h0008_0006, "status_out_full");
        wb_xfer(0, A_CTL, 0, 32'h0, "rd_ctrl_zero");
        fork
            wb_xfer(0, A_DAT, 0, 32'h100, "rd_pop_while_full");
            core_push(32'h999);
        join
        wb_xfer(0, A_ST, 0, 32'h0007_0002, "status_push_refused");
        wb_xfer(0, A_RSV, 0, 32'h0, "rd_reserved");
        wb_xfer(1, A_RSV, 32'hFFFF_FFFF, 0, "wr_reserved");
        wb_xfer(1, A_ST, 32'hFFFF_FFFF, 0, "wr_status");
        wb_xfer(0, A_ST, 0, 32'h0007_0002, "status_unchanged");
        wb_xfer(1, A_CTL, 32'h2, 0, "ctrl_flush_out");
        wb_xfer(0, A_ST, 0, 32'h0000_000A, "status_out_flushed");

        // Simultaneous push and pop at count 1 keeps the count.
        core_push(32'h11);
        fork
            wb_xfer(0, A_DAT, 0, 32'h11, "rd_pop_with_push");
            core_push(32'h22);
        join
        wb_xfer(0, A_ST, 0, 32'h0001_0002, "status_push_pop");
        wb_xfer(0, A_DAT, 0, 32'h22, "rd_second");
        wb_xfer(0, A_ST, 0, 32'h0000_000A, "status_empty_again");

`ifdef WBNN_FIFO_IRQ_EN
        wb_xfer(1, A_CTL, 32'h8, 0, "ctrl_irq_en");
        wb_xfer(0, A_ST, 0, 32'h0000_008A, "status_irq_en");
        for (int i = 0; i < 4; i++) begin
            core_push(32'h200 + i);
        end
        check("irq_not_early", irq_o, 0);
        @(posedge wb_clk_i);
        #1;
        check("irq_thresh", irq_o, 1);
        wb_xfer(0, A_ST, 0, 32'h0004_00C2, "status_irq_high");
        wb_xfer(1, A_CTL, 32'h2, 0, "ctrl_flush_irq");
        check("irq_after_flush", irq_o, 0);
`else
        wb_xfer(1, A_CTL, 32'h8, 0, "ctrl_irq_en_ignored");
        wb_xfer(0, A_ST, 0, 32'h0000_000A, "status_no_irq_bits");
        core_push(32'h1);
        core_push(32'h2);
        core_push(32'h3);
        core_push(32'h4);
        @(posedge wb_clk_i);
        #1;
        check("irq_tied_low", irq_o, 0);
        wb_xfer(1, A_CTL, 32'h2, 0, "ctrl_flush_out2");
`endif

        // Reset in the ack cycle of a DATA write: ack vanishes, push lost.
        wbs_we_i  = 1'b1;
        wbs_adr_i = A_DAT;
        wbs_dat_i = 32'h77;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        wb_rst_ni = 1'b0;
        #1;
        check("midrst_ack", wbs_ack_o, 0);
        check("midrst_in_valid", core_in_valid_o, 0);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(negedge wb_clk_i);
        check("midrst_ack_held", wbs_ack_o, 0);
        wb_rst_ni = 1'b1;
        @(posedge wb_clk_i);
        #1;
        wb_xfer(0, A_ST, 0, 32'h0000_000A, "status_after_midrst");

        // Address just past the window is never acknowledged.
        wbs_adr_i = BASE + 32'h10;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) acks++;
        end
        check("nonhit_no_ack", acks, 0);
        @(posedge wb_clk_i);
        #1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;

        repeat (2) @(posedge wb_clk_i);
        check("bus_scoreboard_drained", bus_q.size(), 0);
        check("core_scoreboard_drained", in_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wishbone_nn_fifo_bridge.md
# wishbone_nn_fifo_bridge

Parametrised Wishbone classic slave giving the management SoC a buffered, flow-controlled data path to the neural-network core. It holds an inbound FIFO (Wishbone → core) and an outbound FIFO (core → Wishbone), plus status and control registers. It uses a registered single-cycle ack, and has sticky overflow/underflow flags and an optional threshold interrupt. It sits between the Caravel Wishbone bus and the NN datapath.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, byte base of the 16-byte register window; bits [3:0] must be 0
- DATA_W, 32, FIFO word width; 1..32, zero-extended onto the bus on reads
- DEPTH, 8, entries per FIFO; power of two, 2..128
- THRESH, DEPTH/2, outbound fill level that raises the interrupt; 1..DEPTH

Ports:
- wb_clk_i  in  1  single clock; everything is on its rising edge
- wb_rst_ni  in  1  reset, asynchronous, active-low
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable
- wbs_sel_i  in  4  byte select; ignored, all accesses are full-word
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  registered acknowledge
- wbs_dat_o  out  32  registered read data
- core_in_valid_o  out  1  inbound FIFO not empty
- core_in_data_o  out  DATA_W  inbound head word (first-word fall-through)
- core_in_ready_i  in  1  core pops inbound head when valid && ready
- core_out_valid_i  in  1  core pushes outbound word when valid && ready
- core_out_data_i  in  DATA_W  outbound word
- core_out_ready_o  out  1  outbound FIFO not full
- irq_o  out  1  registered interrupt, level

## Operation
- Hit: stb && cyc && adr[31:4]==BASE_ADDR[31:4]. Offsets:
  - 0x0 DATA: write pushes wbs_dat_i[DATA_W-1:0] into inbound; read pops the outbound head.
  - 0x4 STATUS: read-only; writes acked and ignored.
  - 0x8 CTRL: write-only; reads return 0. Bit0 flushes inbound, bit1 flushes outbound, bit2 clears sticky flags, bit3 sets irq_en (stored).
  - 0xC: reserved; acked, reads 0, writes ignored.
- A non-hit is never acked and wbs_dat_o stays 0.
- Write DATA while inbound is full: acked, word dropped, sticky ovf set.
- Read DATA while outbound is empty: acked, returns 0, sticky udf set, no pop.
- STATUS layout:
  - [0] in_full, [1] in_empty, [2] out_full, [3] out_empty
  - [4] ovf, [5] udf, [6] irq_o, [7] irq_en
  - [15:8] in_count, [23:16] out_count; other bits 0
- Count width is $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Simultaneous push and pop on one FIFO:
  - Both occur and the count is unchanged.
  - A push while full is refused even if a pop happens in the same cycle.
  - A pop while empty is refused even if a push happens in the same cycle.
- Flush in the same cycle as a push or pop on that FIFO: flush wins; the FIFO ends empty and the push is not counted as an overflow.
- Sticky clear in the same cycle as a new ovf/udf event: the event wins and the flag stays set.

## Timing
- Access accepted in cycle t when hit && !wbs_ack_o. The side effect (push, pop, ctrl) happens at the end of t. wbs_ack_o is high for exactly cycle t+1, together with wbs_dat_o.
- wbs_dat_o returns to 0 in t+2. Back-to-back accesses run at one per 2 cycles.
- STATUS reads sample state at the end of t.
- Core side is 0-latency handshake: core_in_valid_o and core_out_ready_o are combinational from counts. A word pushed at the end of t is visible to the core in t+1.
- irq_o is registered, one cycle after its cause.
- Reset (wb_rst_ni low, any time including mid-access):
  - Immediately: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, core_in_valid_o=0, core_out_ready_o=1.
  - All pointers, counts, ovf, udf and irq_en are cleared.
  - The pending access is lost with no side effect.

## Configuration
- WBNN_FIFO_IRQ_EN defined: irq_o = irq_en && (out_count>=THRESH || ovf || udf), registered.
- Undefined: irq_o tied 0, STATUS[7:6] read 0, CTRL bit3 ignored. No irq_en flop exists.

## Structure
- Package wbnn_fifo_pkg holds:
  - register offset localparams (REG_DATA, REG_STATUS, REG_CTRL)
  - STATUS and CTRL bit-index localparams
- One sub-module, wbnn_sync_fifo (parameters DATA_W, DEPTH; push/pop, flush, full/empty/count). It is instantiated twice. Register decode, ack logic and IRQ logic live in the top.

## Test plan
- Reset then read STATUS → ack 1 cycle after accept; value 0x0000_000A (both empty).
- Write 0x1, 0x2, 0x3 to DATA → core_in_valid_o=1, core_in_data_o=0x1; core pops 3 words in order → in_empty=1.
- DEPTH=8: 9 writes → in_count=8, ovf=1; CTRL write 0x4 → ovf=0.
- Core pushes 0xA5 then 0x5A; 3 DATA reads → 0xA5, 0x5A, 0 with udf=1.
- With WBNN_FIFO_IRQ_EN, CTRL=0x8, THRESH=4: 4 core pushes → irq_o high 1 cycle after the 4th; CTRL=0x2 flush → irq_o low next cycle.
- Assert wb_rst_ni low in the cycle after an accepted DATA write → no ack, in_count=0; read of 0x3000_0010 → never acked.
